// File: rtl/circuit_vec_seq_pkg.sv
// ---------------------------------------------------------------------------
// circuit_vec_seq_pkg
// Shared definitions for the circuit vector sequencer: FSM state encoding,
// vector entry layout and small arithmetic helpers used by the top module.
//
// Optional feature macro (consumed by circuit_vector_sequencer):
//   CIRCUIT_VEC_SEQ_STOP_ON_ERR_EN -- end the run at the first mismatch.
//
// Ports: none (package).
// ---------------------------------------------------------------------------
package circuit_vec_seq_pkg;

  // Vector entry layout: {exp_f, e, a, b, c, d}
  localparam int VEC_W   = 6;
  localparam int EXP_BIT = 5;
  localparam int IN_LSB  = 0;
  localparam int IN_MSB  = 4;

  // Mismatch counter saturation value
  localparam logic [5:0] ERR_MAX = 6'd63;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_APPLY  = 3'd1,
    S_SETTLE = 3'd2,
    S_SAMPLE = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  // Plain-vector constants of the same encoding, for logic-typed state flops
  localparam logic [2:0] ST_IDLE   = S_IDLE;
  localparam logic [2:0] ST_APPLY  = S_APPLY;
  localparam logic [2:0] ST_SETTLE = S_SETTLE;
  localparam logic [2:0] ST_SAMPLE = S_SAMPLE;
  localparam logic [2:0] ST_DONE   = S_DONE;

  // Run length clipped to the depth of the vector store
  function automatic logic [5:0] clip_len(input logic [5:0] req,
                                          input logic [5:0] cap);
    logic [5:0] res;
    if (req > cap) begin
      res = cap;
    end else begin
      res = req;
    end
    return res;
  endfunction

  // Increment that sticks at ERR_MAX instead of wrapping to zero
  function automatic logic [5:0] sat_inc(input logic [5:0] val);
    logic [5:0] res;
    if (val == ERR_MAX) begin
      res = val;
    end else begin
      res = val + 6'd1;
    end
    return res;
  endfunction

  // Field extraction from a stored entry
  function automatic logic [4:0] vec_inputs(input logic [VEC_W-1:0] v);
    return v[IN_MSB:IN_LSB];
  endfunction

  function automatic logic vec_expect(input logic [VEC_W-1:0] v);
    return v[EXP_BIT];
  endfunction

endpackage

// File: rtl/circuit_vec_mem.sv
// ---------------------------------------------------------------------------
// circuit_vec_mem
// NUM_VEC x VEC_W register file holding the stimulus vectors. Synchronous
// write, combinational read. Contents are intentionally not reset so that a
// loaded vector set survives a controller reset.
//
// Ports:
//   clk      in   clock
//   wr_en    in   write strobe (already qualified by the caller)
//   wr_addr  in   [4:0] write index, must be < NUM_VEC when wr_en is high
//   wr_data  in   [VEC_W-1:0] entry {exp_f, e, a, b, c, d}
//   rd_addr  in   [4:0] read index
//   rd_data  out  [VEC_W-1:0] entry at rd_addr
// ---------------------------------------------------------------------------
module circuit_vec_mem
  import circuit_vec_seq_pkg::*;
#(
  parameter int NUM_VEC = 32
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [4:0]       wr_addr,
  input  logic [VEC_W-1:0] wr_data,
  input  logic [4:0]       rd_addr,
  output logic [VEC_W-1:0] rd_data
);

  logic [VEC_W-1:0] mem_q [NUM_VEC];

  // Vector storage write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/circuit_vector_sequencer.sv
// ---------------------------------------------------------------------------
// circuit_vector_sequencer
// Applies a programmable list of input vectors to a five-input gate-level
// circuit, waits SETTLE_CYC cycles for propagation, samples the circuit
// output F against the stored expectation and accumulates the mismatches.
//
// Optional feature macro:
//   CIRCUIT_VEC_SEQ_STOP_ON_ERR_EN -- a mismatch in SAMPLE ends the run
//   immediately (remaining vectors are skipped).
//
// Parameters:
//   NUM_VEC     depth of the vector store (max run length, <= 32)
//   SETTLE_CYC  cycles between applying a vector and sampling F (>= 1)
//
// Ports:
//   clk              in   clock, rising edge
//   rst              in   synchronous active-high reset
//   start            in   run request pulse, honoured only in IDLE
//   run_len          in   [5:0] vectors to apply, latched at start
//   vec_wr_en        in   vector write strobe, honoured only in IDLE
//   vec_wr_addr      in   [4:0] vector write index
//   vec_wr_data      in   [5:0] {exp_f, e, a, b, c, d}
//   dut_f            in   circuit output F
//   dut_in           out  [4:0] {e, a, b, c, d} to the circuit
//   busy             out  run in progress
//   done             out  one-cycle pulse at end of run
//   err_cnt          out  [5:0] saturating mismatch count
//   first_err_valid  out  at least one mismatch this run
//   first_err_idx    out  [4:0] index of the first mismatching vector
// ---------------------------------------------------------------------------
module circuit_vector_sequencer
  import circuit_vec_seq_pkg::*;
#(
  parameter int NUM_VEC    = 32,
  parameter int SETTLE_CYC = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [5:0] run_len,
  input  logic       vec_wr_en,
  input  logic [4:0] vec_wr_addr,
  input  logic [5:0] vec_wr_data,
  input  logic       dut_f,
  output logic [4:0] dut_in,
  output logic       busy,
  output logic       done,
  output logic [5:0] err_cnt,
  output logic       first_err_valid,
  output logic [4:0] first_err_idx
);

  localparam logic [5:0]  NUM_VEC_L   = 6'(NUM_VEC);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);

  logic [2:0]  state_q, state_d;
  logic [5:0]  len_q, len_d;
  logic [4:0]  idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d;
  logic        exp_q, exp_d;
  logic [4:0]  dut_in_q, dut_in_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [5:0]  err_cnt_q, err_cnt_d;
  logic        fev_q, fev_d;
  logic [4:0]  fei_q, fei_d;

  logic             wr_ok_s;
  logic [VEC_W-1:0] rd_data_s;
  logic [5:0]       len_clip_s;
  logic             mismatch_s;
  logic             last_s;

  // Vector writes land only while idle and inside the store
  always_comb begin
    wr_ok_s = 1'b0;
    if (vec_wr_en && (state_q == ST_IDLE) && ({1'b0, vec_wr_addr} < NUM_VEC_L)) begin
      wr_ok_s = 1'b1;
    end else begin
      wr_ok_s = 1'b0;
    end
  end

  circuit_vec_mem #(
    .NUM_VEC (NUM_VEC)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_ok_s),
    .wr_addr (vec_wr_addr),
    .wr_data (vec_wr_data),
    .rd_addr (idx_q),
    .rd_data (rd_data_s)
  );

  // Run bookkeeping: clipped length, compare result and last-vector flag
  always_comb begin
    len_clip_s = clip_len(run_len, NUM_VEC_L);
    mismatch_s = (dut_f != exp_q);
    // len_q >= 1 whenever SAMPLE is reachable, so len_q - 1 never wraps here
    last_s     = ({1'b0, idx_q} == (len_q - 6'd1));
  end

  // Next-state and datapath update for the sequencer FSM
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    exp_d     = exp_q;
    dut_in_d  = dut_in_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_cnt_d = err_cnt_q;
    fev_d     = fev_q;
    fei_d     = fei_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d     = len_clip_s;
          idx_d     = 5'd0;
          err_cnt_d = 6'd0;
          fev_d     = 1'b0;
          fei_d     = 5'd0;
          busy_d    = 1'b1;
          if (len_clip_s == 6'd0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_APPLY;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_APPLY: begin
        dut_in_d = vec_inputs(rd_data_s);
        exp_d    = vec_expect(rd_data_s);
        cnt_d    = 16'd0;
        state_d  = ST_SETTLE;
      end

      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      ST_SAMPLE: begin
        if (mismatch_s) begin
          err_cnt_d = sat_inc(err_cnt_q);
          if (!fev_q) begin
            fev_d = 1'b1;
            fei_d = idx_q;
          end else begin
            fev_d = fev_q;
          end
        end else begin
          err_cnt_d = err_cnt_q;
        end
`ifdef CIRCUIT_VEC_SEQ_STOP_ON_ERR_EN
        if (mismatch_s || last_s) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          idx_d   = idx_q + 5'd1;
          state_d = ST_APPLY;
        end
`else
        if (last_s) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          idx_d   = idx_q + 5'd1;
          state_d = ST_APPLY;
        end
`endif
      end

      // done_q is already high for this cycle; busy drops as we leave
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      len_q     <= 6'd0;
      idx_q     <= 5'd0;
      cnt_q     <= 16'd0;
      exp_q     <= 1'b0;
      dut_in_q  <= 5'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_cnt_q <= 6'd0;
      fev_q     <= 1'b0;
      fei_q     <= 5'd0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      exp_q     <= exp_d;
      dut_in_q  <= dut_in_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_cnt_q <= err_cnt_d;
      fev_q     <= fev_d;
      fei_q     <= fei_d;
    end
  end

  assign dut_in          = dut_in_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign err_cnt         = err_cnt_q;
  assign first_err_valid = fev_q;
  assign first_err_idx   = fei_q;

endmodule

// File: tb/tb_circuit_vector_sequencer.sv
// ---------------------------------------------------------------------------
// tb_circuit_vector_sequencer
// Self-checking bench: a behavioural model of the gate-level circuit drives
// dut_f, and expected run results / timing come from a per-run reference
// computed directly from the vector list.
// ---------------------------------------------------------------------------
module tb_circuit_vector_sequencer;

  localparam int NV  = 32;
  localparam int SC  = 4;
  localparam int PER = SC + 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [5:0] run_len;
  logic       vec_wr_en;
  logic [4:0] vec_wr_addr;
  logic [5:0] vec_wr_data;
  logic       dut_f;
  logic [4:0] dut_in;
  logic       busy;
  logic       done;
  logic [5:0] err_cnt;
  logic       first_err_valid;
  logic [4:0] first_err_idx;

  int checks = 0;
  int errors = 0;

  logic [5:0] mem_m [NV];
  logic [4:0] prev_in;

  // Reference gate-level circuit: v = {e, a, b, c, d}
  function automatic logic f_ref(input logic [4:0] v);
    logic e, a, b, c, d;
    {e, a, b, c, d} = v;
    return (a & b) | (c & ~d) | (e & ~a);
  endfunction

  assign dut_f = f_ref(dut_in);

  always #5 clk = ~clk;

  circuit_vector_sequencer #(
    .NUM_VEC    (NV),
    .SETTLE_CYC (SC)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .run_len         (run_len),
    .vec_wr_en       (vec_wr_en),
    .vec_wr_addr     (vec_wr_addr),
    .vec_wr_data     (vec_wr_data),
    .dut_f           (dut_f),
    .dut_in          (dut_in),
    .busy            (busy),
    .done            (done),
    .err_cnt         (err_cnt),
    .first_err_valid (first_err_valid),
    .first_err_idx   (first_err_idx)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] mk_vec(input bit bad);
    logic [4:0] v;
    v = 5'($urandom);
    return {f_ref(v) ^ bad, v};
  endfunction

  task automatic wr_vec(input logic [4:0] a, input logic [5:0] d);
    @(negedge clk);
    vec_wr_en   = 1'b1;
    vec_wr_addr = a;
    vec_wr_data = d;
    @(negedge clk);
    vec_wr_en = 1'b0;
    mem_m[a]  = d;
  endtask

  // One complete run: per-cycle check of busy/dut_in, then latency and results
  task automatic run(input int len, input bit disturb, input bit do_wr,
                     input logic [4:0] wa, input logic [5:0] wd);
    int L, n_app, n_err, first, done_k, k, j;
    bit mm, fev_e;
    logic [4:0] exp_in, last_in;
    L = (len > NV) ? NV : len;
    if (do_wr) mem_m[wa] = wd;
    n_app = 0; n_err = 0; first = 0; fev_e = 1'b0;
    for (int i = 0; i < L; i++) begin
      n_app = i + 1;
      mm = (f_ref(mem_m[i][4:0]) != mem_m[i][5]);
      if (mm) begin
        if (n_err < 63) n_err++;
        if (!fev_e) begin fev_e = 1'b1; first = i; end
      end
`ifdef CIRCUIT_VEC_SEQ_STOP_ON_ERR_EN
      if (mm) break;
`endif
    end
    done_k  = n_app * PER + 1;
    last_in = (n_app > 0) ? mem_m[n_app-1][4:0] : prev_in;

    @(negedge clk);
    start   = 1'b1;
    run_len = 6'(len);
    if (do_wr) begin
      vec_wr_en = 1'b1; vec_wr_addr = wa; vec_wr_data = wd;
    end
    @(negedge clk);
    start = 1'b0; vec_wr_en = 1'b0;
    k = 1;
    while (k <= 3000 && done !== 1'b1) begin
      if (disturb && k == 3) begin
        start = 1'b1; run_len = 6'($urandom_range(1, 63));
        vec_wr_en = 1'b1; vec_wr_addr = 5'($urandom); vec_wr_data = 6'($urandom);
      end else if (disturb && k == 4) begin
        start = 1'b0; vec_wr_en = 1'b0;
      end
      j = (k < 2) ? -1 : (k - 2) / PER;
      if (j > n_app - 1) j = n_app - 1;
      exp_in = (j < 0) ? prev_in : mem_m[j][4:0];
      chk("busy_run", busy, 1);
      chk("dut_in_run", dut_in, exp_in);
      @(negedge clk);
      k++;
    end
    start = 1'b0; vec_wr_en = 1'b0;
    chk("done_latency", k, done_k);
    chk("dut_in_at_done", dut_in, last_in);
    chk("err_cnt", err_cnt, n_err);
    chk("first_err_valid", first_err_valid, fev_e);
    chk("first_err_idx", first_err_idx, first);
    prev_in = last_in;
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("busy_after", busy, 0);
    chk("err_cnt_hold", err_cnt, n_err);
    chk("dut_in_hold", dut_in, last_in);
  endtask

  initial begin
    int cnt_done;
    rst = 1'b1; start = 1'b0; run_len = 6'd0;
    vec_wr_en = 1'b0; vec_wr_addr = 5'd0; vec_wr_data = 6'd0;
    prev_in = 5'd0;
    repeat (3) @(negedge clk);
    chk("rst_dut_in", dut_in, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_fev", first_err_valid, 0);
    chk("rst_fei", first_err_idx, 0);
    rst = 1'b0;

    // Four correct vectors
    for (int i = 0; i < NV; i++) wr_vec(5'(i), mk_vec(1'b0));
    run(4, 1'b0, 1'b0, 5'd0, 6'd0);

    // Entries 1 and 3 with wrong expectation
    wr_vec(5'd1, mk_vec(1'b1));
    wr_vec(5'd3, mk_vec(1'b1));
    run(4, 1'b0, 1'b0, 5'd0, 6'd0);

    // Zero-length run
    run(0, 1'b0, 1'b0, 5'd0, 6'd0);

    // Random full store, run_len beyond depth
    for (int i = 0; i < NV; i++) wr_vec(5'(i), mk_vec($urandom_range(0, 3) == 0));
    run(40, 1'b0, 1'b0, 5'd0, 6'd0);

    // start / write while busy are ignored
    run(5, 1'b1, 1'b0, 5'd0, 6'd0);
    run(NV, 1'b0, 1'b0, 5'd0, 6'd0);

    // Write and start in the same idle cycle: run sees the new entry
    run(1, 1'b0, 1'b1, 5'd0, mk_vec(1'b1));

    // Reset during SETTLE of vector 2
    wr_vec(5'd1, mk_vec(1'b0));
    wr_vec(5'd2, mk_vec(1'b0));
    @(negedge clk);
    start = 1'b1; run_len = 6'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_err_cnt", err_cnt, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_dut_in", dut_in, 0);
    chk("midrst_err_cnt", err_cnt, 0);
    chk("midrst_fev", first_err_valid, 0);
    chk("midrst_done", done, 0);
    cnt_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) cnt_done++;
    end
    chk("midrst_no_done", cnt_done, 0);
    prev_in = 5'd0;

    // Random run after the reset, memory kept across reset
    run($urandom_range(1, NV), 1'b0, 1'b0, 5'd0, 6'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
